// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the ALU arbiter: opcode encodings, data width and FSM states.
package alu_arbiter_pkg;

  localparam int unsigned DataWidth = 64;

  localparam logic [3:0] OpAnd   = 4'b0000;
  localparam logic [3:0] OpOrr   = 4'b0001;
  localparam logic [3:0] OpAdd   = 4'b0010;
  localparam logic [3:0] OpSub   = 4'b0110;
  localparam logic [3:0] OpPassB = 4'b0111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 64-bit ALU. Unknown opcodes yield zero; legality is judged by the caller.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [DataWidth-1:0] a_i,
  input  logic [DataWidth-1:0] b_i,
  input  logic [3:0]           ctrl_i,
  output logic [DataWidth-1:0] w_o,
  output logic                 zero_o
);

  // Opcode decode and datapath
  always_comb begin
    w_o = '0;
    case (ctrl_i)
      OpAnd:   w_o = a_i & b_i;
      OpOrr:   w_o = a_i | b_i;
      OpAdd:   w_o = a_i + b_i;
      OpSub:   w_o = a_i - b_i;
      OpPassB: w_o = b_i;
      default: w_o = '0;
    endcase
    zero_o = (w_o == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU.
// One operation in flight: IDLE (accept) -> EXEC (compute) -> RESP (hold until taken).
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_a,
  input  logic [63:0] req0_b,
  input  logic [3:0]  req0_ctrl,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_a,
  input  logic [63:0] req1_b,
  input  logic [3:0]  req1_ctrl,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_w,
  output logic        rsp_zero,
  output logic        rsp_err
);

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;

  logic [63:0] op_a_q, op_a_d;
  logic [63:0] op_b_q, op_b_d;
  logic [3:0]  op_ctrl_q, op_ctrl_d;
  logic        op_id_q, op_id_d;

  logic        rsp_id_q, rsp_id_d;
  logic [63:0] rsp_w_q, rsp_w_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        rsp_err_q, rsp_err_d;

  logic        grant_valid;
  logic        grant_id;
  logic        accept;
  logic        op_legal;
  logic [63:0] alu_w;
  logic        alu_zero;

  // Round-robin pick: lone requester wins, contention goes to whoever was not served last
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = ~last_grant_q;
    end else if (req0_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  // Ready only in IDLE and never while reset is asserted; grant implies valid, so ready == accept
  assign accept     = (state_q == StIdle) && grant_valid && rst_n;
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;
  assign rsp_valid  = (state_q == StResp);

  assign rsp_id   = rsp_id_q;
  assign rsp_w    = rsp_w_q;
  assign rsp_zero = rsp_zero_q;
  assign rsp_err  = rsp_err_q;

  // Opcode legality check on the latched opcode
  always_comb begin
    op_legal = 1'b0;
    case (op_ctrl_q)
      OpAnd, OpOrr, OpAdd, OpSub, OpPassB: op_legal = 1'b1;
      default:                             op_legal = 1'b0;
    endcase
  end

  alu u_alu (
    .a_i    (op_a_q),
    .b_i    (op_b_q),
    .ctrl_i (op_ctrl_q),
    .w_o    (alu_w),
    .zero_o (alu_zero)
  );

  // FSM next state, operand capture on accept and result capture at the end of EXEC
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_ctrl_d    = op_ctrl_q;
    op_id_d      = op_id_q;
    rsp_id_d     = rsp_id_q;
    rsp_w_d      = rsp_w_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d      = StExec;
          last_grant_d = grant_id;
          op_id_d      = grant_id;
          op_a_d       = grant_id ? req1_a : req0_a;
          op_b_d       = grant_id ? req1_b : req0_b;
          op_ctrl_d    = grant_id ? req1_ctrl : req0_ctrl;
        end
      end
      StExec: begin
        state_d    = StResp;
        rsp_id_d   = op_id_q;
        rsp_w_d    = op_legal ? alu_w : '0;
        rsp_zero_d = op_legal ? alu_zero : 1'b1;
        rsp_err_d  = ~op_legal;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; last_grant resets to 1 so req0 wins the first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_ctrl_q    <= '0;
      op_id_q      <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_w_q      <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_ctrl_q    <= op_ctrl_d;
      op_id_q      <= op_id_d;
      rsp_id_q     <= rsp_id_d;
      rsp_w_q      <= rsp_w_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed table, corner sequences and random traffic
// against a transaction-level reference model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [63:0] rsp_w;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ctrl  (req0_ctrl),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ctrl  (req1_ctrl),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_w      (rsp_w),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model: one outstanding op; response visible from the second cycle after accept
  bit          m_busy;
  int          m_age;
  bit          m_last;
  bit          m_id;
  logic [63:0] m_w;
  bit          m_z, m_e;
  bit          grants[$];

  bit          saw_rsp;
  bit          obs_id, obs_z, obs_e;
  logic [63:0] obs_w;

  typedef struct {
    bit          id;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  ctrl;
    logic [63:0] w;
    bit          z;
    bit          e;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out waiting, expected event", name);
  endtask

  function automatic void ref_alu(input logic [63:0] a, input logic [63:0] b,
                                  input logic [3:0] c, output logic [63:0] w,
                                  output bit z, output bit e);
    e = 1'b0;
    case (c)
      4'd0:    w = a & b;
      4'd1:    w = a | b;
      4'd2:    w = a + b;
      4'd6:    w = a - b;
      4'd7:    w = b;
      default: begin w = 64'd0; e = 1'b1; end
    endcase
    z = (w == 64'd0);
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_age  = 0;
    m_last = 1'b1;
  endtask

  // Called at a negedge with inputs set: check outputs, advance model over the next posedge
  task automatic tick();
    bit e_r0, e_r1, e_v, g;
    #1;
    e_v  = m_busy && (m_age >= 1);
    e_r0 = 1'b0;
    e_r1 = 1'b0;
    if (!m_busy && (req0_valid || req1_valid)) begin
      g = (req0_valid && req1_valid) ? !m_last : !req0_valid;
      if (g) e_r1 = 1'b1;
      else   e_r0 = 1'b1;
    end
    chk("req0_ready", req0_ready, e_r0);
    chk("req1_ready", req1_ready, e_r1);
    chk("rsp_valid", rsp_valid, e_v);
    saw_rsp = rsp_valid;
    obs_id  = rsp_id;
    obs_w   = rsp_w;
    obs_z   = rsp_zero;
    obs_e   = rsp_err;
    if (e_v) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_w", rsp_w, m_w);
      chk("rsp_zero", rsp_zero, m_z);
      chk("rsp_err", rsp_err, m_e);
    end
    @(posedge clk);
    if (!m_busy) begin
      if (e_r0 || e_r1) begin
        m_busy = 1'b1;
        m_age  = 0;
        m_id   = e_r1;
        m_last = e_r1;
        grants.push_back(e_r1);
        if (e_r1) ref_alu(req1_a, req1_b, req1_ctrl, m_w, m_z, m_e);
        else      ref_alu(req0_a, req0_b, req0_ctrl, m_w, m_z, m_e);
      end
    end else if (m_age >= 1 && rsp_ready) begin
      m_busy = 1'b0;
    end else begin
      m_age++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_accept(input string name);
    int pre;
    pre = grants.size();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (grants.size() > pre) return;
    end
    timeout(name);
  endtask

  task automatic wait_rsp(input string name);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (saw_rsp) return;
    end
    timeout(name);
  endtask

  task automatic drain();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    for (int i = 0; i < 10 && m_busy; i++) tick();
    if (m_busy) timeout("drain");
  endtask

  task automatic set_req(input bit id, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] c);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctrl = c;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctrl = c;
    end
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b0, 64'd5, 64'd3, 4'b0010, 64'd8, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 64'd7, 64'd7, 4'b0110, 64'd0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 64'd1, 64'd1, 4'b0011, 64'd0, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 64'd0, 64'd1, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 4'b0000,
               64'hF000_F000_F000_F000, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 4'b0001,
               64'hFFF0_FFF0_FFF0_FFF0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 64'd0, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 64'd123, 64'hDEAD_BEEF, 4'b0111, 64'hDEAD_BEEF, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 64'd0, 64'd0, 4'b1111, 64'd0, 1'b1, 1'b1};

    req0_a = '0; req0_b = '0; req0_ctrl = '0;
    req1_a = '0; req1_b = '0; req1_ctrl = '0;
    rsp_ready = 1'b1;

    // Reset state: readies held low even with both requesters valid
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rst_n = 1'b0;
    model_reset();
    #12;
    chk("reset req0_ready", req0_ready, 1'b0);
    chk("reset req1_ready", req1_ready, 1'b0);
    chk("reset rsp_valid", rsp_valid, 1'b0);
    chk("reset rsp_w", rsp_w, 64'd0);
    chk("reset rsp_id", rsp_id, 1'b0);
    chk("reset rsp_zero", rsp_zero, 1'b0);
    chk("reset rsp_err", rsp_err, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed table, one requester at a time
    foreach (tbl[i]) begin
      set_req(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].ctrl);
      wait_accept("tbl accept");
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_rsp("tbl rsp");
      chk("tbl rsp_id", obs_id, tbl[i].id);
      chk("tbl rsp_w", obs_w, tbl[i].w);
      chk("tbl rsp_zero", obs_z, tbl[i].z);
      chk("tbl rsp_err", obs_e, tbl[i].e);
      drain();
    end

    // Contention after reset alternates starting with req0
    do_reset();
    grants.delete();
    set_req(1'b0, 64'd1, 64'd2, 4'b0010);
    set_req(1'b1, 64'd3, 64'd4, 4'b0010);
    repeat (12) tick();
    if (grants.size() < 4) timeout("alternation grants");
    else for (int i = 0; i < 4; i++) chk("alternating grant", grants[i], i % 2);
    drain();

    // Response held stable under back-pressure; req0 pending must not see ready
    rsp_ready = 1'b0;
    set_req(1'b1, 64'd7, 64'd7, 4'b0110);
    wait_accept("hold accept");
    req1_valid = 1'b0;
    set_req(1'b0, 64'd9, 64'd1, 4'b0110);
    wait_rsp("hold rsp");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold rsp_w", obs_w, 64'd0);
      chk("hold rsp_zero", obs_z, 1'b1);
      chk("hold rsp_id", obs_id, 1'b1);
    end
    rsp_ready = 1'b1;
    tick();
    tick();
    drain();

    // Operands changed right after accept must not leak into the result
    set_req(1'b0, 64'd10, 64'd20, 4'b0010);
    wait_accept("latch accept");
    req0_valid = 1'b0;
    req0_a = 64'd1000;
    req0_b = 64'd1;
    req0_ctrl = 4'b0110;
    wait_rsp("latch rsp");
    chk("latched rsp_w", obs_w, 64'd30);
    drain();

    // Asynchronous reset during EXEC
    set_req(1'b1, 64'd11, 64'd22, 4'b0010);
    wait_accept("async accept");
    set_req(1'b0, 64'd5, 64'd5, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rsp_valid", rsp_valid, 1'b0);
    chk("async req0_ready", req0_ready, 1'b0);
    chk("async req1_ready", req1_ready, 1'b0);
    chk("async rsp_w", rsp_w, 64'd0);
    model_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    set_req(1'b0, 64'd1, 64'd1, 4'b0000);
    set_req(1'b1, 64'd2, 64'd2, 4'b0000);
    wait_accept("post-reset accept");
    chk("post-reset grant", grants[$], 1'b0);
    drain();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_a = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
      req0_b = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
      req1_a = {$urandom, $urandom};
      req1_b = ($urandom_range(0, 3) == 0) ? req1_a : {$urandom, $urandom};
      req0_ctrl = 4'($urandom_range(0, 15));
      req1_ctrl = ($urandom_range(0, 1) == 0) ? 4'b0110 : 4'($urandom_range(0, 7));
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
